// File: rtl/watch_pkg.sv
// Shared types and constants for the watch time-setting path: FSM states,
// digit positions, per-position digit limits and nibble placement in time_bcd.
package watch_pkg;

    localparam int NUM_KEYS = 10;
    localparam int NUM_POS  = 6;
    localparam int TIME_W   = 4 * NUM_POS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [2:0] POS_HT = 3'd0;
    localparam logic [2:0] POS_HO = 3'd1;
    localparam logic [2:0] POS_MT = 3'd2;
    localparam logic [2:0] POS_MO = 3'd3;
    localparam logic [2:0] POS_ST = 3'd4;
    localparam logic [2:0] POS_SO = 3'd5;

    localparam logic [3:0] MAX_HT    = 4'd2;
    localparam logic [3:0] MAX_HO    = 4'd9;
    localparam logic [3:0] MAX_HO_20 = 4'd3;
    localparam logic [3:0] MAX_MT    = 4'd5;
    localparam logic [3:0] MAX_MO    = 4'd9;
    localparam logic [3:0] MAX_ST    = 4'd5;
    localparam logic [3:0] MAX_SO    = 4'd9;

    localparam logic [4:0] OFF_HT = 5'd20;
    localparam logic [4:0] OFF_HO = 5'd16;
    localparam logic [4:0] OFF_MT = 5'd12;
    localparam logic [4:0] OFF_MO = 5'd8;
    localparam logic [4:0] OFF_ST = 5'd4;
    localparam logic [4:0] OFF_SO = 5'd0;

    // Hours-ones is limited to 0-3 once the tens digit is 2 (no hour 24+).
    function automatic logic [3:0] max_digit(input logic [2:0] pos, input logic [3:0] h_ten);
        logic [3:0] lim;
        case (pos)
            POS_HT:  lim = MAX_HT;
            POS_HO:  lim = (h_ten == 4'd2) ? MAX_HO_20 : MAX_HO;
            POS_MT:  lim = MAX_MT;
            POS_MO:  lim = MAX_MO;
            POS_ST:  lim = MAX_ST;
            default: lim = MAX_SO;
        endcase
        return lim;
    endfunction

    function automatic logic [4:0] nib_off(input logic [2:0] pos);
        logic [4:0] off;
        case (pos)
            POS_HT:  off = OFF_HT;
            POS_HO:  off = OFF_HO;
            POS_MT:  off = OFF_MT;
            POS_MO:  off = OFF_MO;
            POS_ST:  off = OFF_ST;
            default: off = OFF_SO;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Keypad/switch inputs and watch-counter/display outputs of the time-setting block.
interface time_set_ctrl_if;

    logic                             set_req;
    logic [watch_pkg::NUM_KEYS-1:0]   keypad;
    logic                             load;
    logic [watch_pkg::TIME_W-1:0]     time_bcd;
    logic                             editing;
    logic [watch_pkg::NUM_POS-1:0]    blink_mask;
    logic                             err;
    logic                             abort;

    modport master (
        output set_req, keypad,
        input  load, time_bcd, editing, blink_mask, err, abort
    );

    modport slave (
        input  set_req, keypad,
        output load, time_bcd, editing, blink_mask, err, abort
    );

endinterface

// File: rtl/key_debounce.sv
// Keypad debouncer: a single key, pressed from an all-released keypad and held
// stable for DEB_CYCLES cycles, yields one key_valid pulse with its digit.
module key_debounce
    import watch_pkg::*;
#(
    parameter int DEB_CYCLES = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic                key_valid,
    output logic [3:0]          key_val
);

    localparam int              CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES);

    logic [NUM_KEYS-1:0] code_q, code_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                armed_q, armed_d;
    logic                valid_q, valid_d;
    logic [3:0]          val_q, val_d;
    logic                one_hot;

    assign one_hot = (keypad != '0) && ((keypad & (keypad - NUM_KEYS'(1))) == '0);

    always_comb begin
        code_d  = keypad;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        valid_d = 1'b0;
        val_d   = val_q;

        if (!one_hot)
            cnt_d = '0;
        else if (keypad != code_q)
            cnt_d = CNT_W'(1);
        else if (cnt_q != DEB_MAX)
            cnt_d = cnt_q + CNT_W'(1);

        // Sliding from one pressed code to another without a full release disarms.
        if (keypad == '0)
            armed_d = 1'b1;
        else if ((code_q != '0) && (keypad != code_q))
            armed_d = 1'b0;

        if (armed_d && (cnt_d == DEB_MAX)) begin
            valid_d = 1'b1;
            armed_d = 1'b0;
            for (int i = 0; i < NUM_KEYS; i++)
                if (keypad[i]) val_d = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            val_q   <= '0;
        end else begin
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            val_q   <= val_d;
        end
    end

    assign key_valid = valid_q;
    assign key_val   = val_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad-driven time-setting controller: collects six range-checked HHMMSS digits
// and hands the finished BCD time to the watch counter with a one-cycle load strobe.
module time_set_ctrl
    import watch_pkg::*;
#(
    parameter int DEB_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic            clk,
    input  logic            rst,
    time_set_ctrl_if.slave  bus
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic                set_prev_q, set_prev_d;
    logic [2:0]          pos_q, pos_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                load_q, load_d;
    logic                err_q, err_d;
    logic                abort_q, abort_d;
    logic                editing_q, editing_d;
    logic [NUM_POS-1:0]  blink_q, blink_d;

    logic                key_valid;
    logic [3:0]          key_val;
    logic                digit_ok;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk       (clk),
        .rst       (rst),
        .keypad    (bus.keypad),
        .key_valid (key_valid),
        .key_val   (key_val)
    );

    assign digit_ok = (key_val <= max_digit(pos_q, time_q[OFF_HT +: 4]));

    always_comb begin
        state_d    = state_q;
        set_prev_d = bus.set_req;
        pos_d      = pos_q;
        time_d     = time_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        abort_d    = 1'b0;
        load_d     = (state_q == ST_COMMIT);

        case (state_q)
            ST_IDLE: begin
                if (bus.set_req && !set_prev_q) begin
                    state_d = ST_ENTRY;
                    pos_d   = POS_HT;
                    time_d  = '0;
                    tmo_d   = '0;
                end
            end
            ST_ENTRY: begin
                if (!bus.set_req) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (key_valid) begin
                    tmo_d = '0;
                    if (digit_ok) begin
                        time_d[nib_off(pos_q) +: 4] = key_val;
                        if (pos_q == POS_SO)
                            state_d = ST_COMMIT;
                        else
                            pos_d = pos_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        editing_d = (state_d == ST_ENTRY);
        blink_d   = editing_d ? (6'b100000 >> pos_d) : '0;
    end

    // set_prev resets high so a switch already on when reset lifts is not a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            set_prev_q <= 1'b1;
            pos_q      <= '0;
            time_q     <= '0;
            tmo_q      <= '0;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            editing_q  <= 1'b0;
            blink_q    <= '0;
        end else begin
            state_q    <= state_d;
            set_prev_q <= set_prev_d;
            pos_q      <= pos_d;
            time_q     <= time_d;
            tmo_q      <= tmo_d;
            load_q     <= load_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            editing_q  <= editing_d;
            blink_q    <= blink_d;
        end
    end

    assign bus.load       = load_q;
    assign bus.time_bcd   = time_q;
    assign bus.editing    = editing_q;
    assign bus.blink_mask = blink_q;
    assign bus.err        = err_q;
    assign bus.abort      = abort_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: table-driven digit sequences, hand-written corner
// sequences and random key sequences checked against a digit-level model.
module tb_time_set_ctrl;
    import watch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    time_set_ctrl_if bus ();

    time_set_ctrl #(.DEB_CYCLES(20), .TIMEOUT_CYCLES(10000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int load_cnt = 0, err_cnt = 0, abort_cnt = 0;

    // Pulse counters sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (bus.load)  load_cnt++;
            if (bus.err)   err_cnt++;
            if (bus.abort) abort_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Digit-level model: the digits entered so far and the next position.
    int m_dig[6];
    int m_pos;
    int m_err;

    function automatic int m_limit(input int p);
        case (p)
            0: return 2;
            1: return (m_dig[0] == 2) ? 3 : 9;
            2: return 5;
            3: return 9;
            4: return 5;
            default: return 9;
        endcase
    endfunction

    function automatic logic [31:0] m_time();
        int t = 0;
        for (int i = 0; i < 6; i++) t = t * 16 + m_dig[i];
        return 32'(t);
    endfunction

    function automatic logic [31:0] m_blink();
        return 32'(32 >> m_pos);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_raw(input logic [9:0] code, input int hold, input int gap);
        bus.keypad = code;
        cyc(hold);
        bus.keypad = '0;
        cyc(gap);
    endtask

    task automatic do_key(input int k, input int hold, input int gap);
        if (m_pos < 6) begin
            if (k <= m_limit(m_pos)) begin
                m_dig[m_pos] = k;
                m_pos++;
            end else begin
                m_err++;
            end
        end
        press_raw(10'(1 << k), hold, gap);
        if (m_pos < 6) begin
            chk("blink_mask", 32'(bus.blink_mask), m_blink());
            chk("time_partial", 32'(bus.time_bcd), m_time());
        end else begin
            chk("editing_after_commit", 32'(bus.editing), 32'd0);
        end
    endtask

    task automatic start_entry();
        bus.set_req = 1'b0;
        cyc(3);
        bus.set_req = 1'b1;
        cyc(3);
        for (int i = 0; i < 6; i++) m_dig[i] = 0;
        m_pos = 0;
        m_err = 0;
        chk("editing_start", 32'(bus.editing), 32'd1);
        chk("blink_start", 32'(bus.blink_mask), 32'h20);
        chk("time_start", 32'(bus.time_bcd), 32'd0);
    endtask

    typedef struct {
        int          n;
        logic [39:0] keys;
        logic [23:0] exp_time;
        int          exp_err;
        int          exp_load;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int l0, e0, a0;
        vecs[0] = '{6, 40'h123456,    24'h123456, 0, 1};
        vecs[1] = '{7, 40'h2535959,   24'h235959, 1, 1};
        vecs[2] = '{9, 40'h712659659, 24'h125959, 3, 1};
        vecs[3] = '{6, 40'h000000,    24'h000000, 0, 1};
        vecs[4] = '{7, 40'h2400000,   24'h200000, 1, 1};

        rst = 1'b1;
        bus.set_req = 1'b0;
        bus.keypad = '0;
        cyc(3);
        chk("rst_load", 32'(bus.load), 32'd0);
        chk("rst_time", 32'(bus.time_bcd), 32'd0);
        chk("rst_editing", 32'(bus.editing), 32'd0);
        chk("rst_blink", 32'(bus.blink_mask), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_abort", 32'(bus.abort), 32'd0);
        rst = 1'b0;
        cyc(3);

        for (int v = 0; v < 5; v++) begin
            start_entry();
            l0 = load_cnt; e0 = err_cnt; a0 = abort_cnt;
            for (int i = 0; i < vecs[v].n; i++)
                do_key(int'(vecs[v].keys[4*(vecs[v].n-1-i) +: 4]), 30, 5);
            cyc(3);
            chk("vec_load", 32'(load_cnt - l0), 32'(vecs[v].exp_load));
            chk("vec_err", 32'(err_cnt - e0), 32'(vecs[v].exp_err));
            chk("vec_abort", 32'(abort_cnt - a0), 32'd0);
            chk("vec_time", 32'(bus.time_bcd), 32'(vecs[v].exp_time));
            cyc(10);
            chk("no_restart_held", 32'(bus.editing), 32'd0);
        end

        // Debounce corners, then cancel after three digits.
        start_entry();
        l0 = load_cnt; e0 = err_cnt; a0 = abort_cnt;
        press_raw(10'b0000000010, 10, 5);
        chk("short_press_blink", 32'(bus.blink_mask), 32'h20);
        chk("short_press_time", 32'(bus.time_bcd), 32'd0);
        do_key(1, 500, 5);
        press_raw(10'b0000011000, 30, 5);
        chk("multi_key_blink", 32'(bus.blink_mask), 32'h10);
        chk("multi_key_time", 32'(bus.time_bcd), 32'h100000);
        do_key(2, 30, 5);
        do_key(3, 30, 5);
        chk("debounce_err", 32'(err_cnt - e0), 32'd0);
        bus.set_req = 1'b0;
        cyc(3);
        chk("cancel_abort", 32'(abort_cnt - a0), 32'd1);
        chk("cancel_load", 32'(load_cnt - l0), 32'd0);
        chk("cancel_editing", 32'(bus.editing), 32'd0);
        chk("cancel_blink", 32'(bus.blink_mask), 32'd0);

        // Inactivity timeout.
        start_entry();
        l0 = load_cnt; a0 = abort_cnt;
        cyc(9990);
        chk("tmo_early_editing", 32'(bus.editing), 32'd1);
        chk("tmo_early_abort", 32'(abort_cnt - a0), 32'd0);
        cyc(20);
        chk("tmo_abort", 32'(abort_cnt - a0), 32'd1);
        chk("tmo_editing", 32'(bus.editing), 32'd0);
        chk("tmo_load", 32'(load_cnt - l0), 32'd0);

        // Asynchronous reset mid-entry, set_req kept high throughout.
        start_entry();
        do_key(1, 30, 5);
        do_key(2, 30, 5);
        l0 = load_cnt; a0 = abort_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_time", 32'(bus.time_bcd), 32'd0);
        chk("arst_editing", 32'(bus.editing), 32'd0);
        chk("arst_blink", 32'(bus.blink_mask), 32'd0);
        chk("arst_load", 32'(bus.load), 32'd0);
        chk("arst_err", 32'(bus.err), 32'd0);
        chk("arst_abort", 32'(bus.abort), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(40);
        chk("arst_no_reentry", 32'(bus.editing), 32'd0);
        chk("arst_no_abort", 32'(abort_cnt - a0), 32'd0);
        chk("arst_no_load", 32'(load_cnt - l0), 32'd0);

        // Random key sequences.
        for (int r = 0; r < 8; r++) begin
            int nk = 0;
            start_entry();
            l0 = load_cnt; e0 = err_cnt; a0 = abort_cnt;
            while (m_pos < 6 && nk < 14) begin
                do_key(int'($urandom_range(0, 9)), int'($urandom_range(25, 60)),
                       int'($urandom_range(3, 10)));
                nk++;
            end
            cyc(3);
            chk("rnd_err", 32'(err_cnt - e0), 32'(m_err));
            if (m_pos == 6) begin
                chk("rnd_load", 32'(load_cnt - l0), 32'd1);
                chk("rnd_time", 32'(bus.time_bcd), m_time());
            end else begin
                bus.set_req = 1'b0;
                cyc(3);
                chk("rnd_abort", 32'(abort_cnt - a0), 32'd1);
                chk("rnd_load_none", 32'(load_cnt - l0), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Keypad-driven time-setting controller for the 1 kHz digital watch. It debounces the 10-key keypad and collects six HHMMSS digits, checking each digit's range as it is entered. On completion it issues a single-cycle load strobe with the BCD time to the watch counter. It sits between the keypad/switch inputs and the watch counter/7-segment display, replacing free-running per-clock keypad sampling.

## Interface
- DEB_CYCLES, 20: consecutive cycles a one-hot key code must be stable to count as a press.
- TIMEOUT_CYCLES, 10000: idle cycles in ENTRY without an accepted key before abort (10 s at 1 kHz).
- clk  in  1  system clock, 1 kHz.
- rst  in  1  reset, asynchronous, active-high.
- set_req  in  1  set-mode switch level; rising edge starts entry, low cancels.
- keypad  in  10  raw key lines, bit k = digit k, active-high.
- load  out  1  one-cycle strobe: time_bcd is a complete, valid time.
- time_bcd  out  24  {h_ten,h_one,m_ten,m_one,s_ten,s_one}, 4 bits each.
- editing  out  1  high while in ENTRY.
- blink_mask  out  6  one-hot digit under edit (bit 5 = h_ten … bit 0 = s_one); 0 outside ENTRY.
- err  out  1  one-cycle pulse when a pressed digit is out of range.
- abort  out  1  one-cycle pulse when entry ends by cancel or timeout.

## Operation
- FSM states: IDLE, ENTRY, COMMIT.
- IDLE:
  - A set_req rising edge (registered previous value 0, current 1) moves to ENTRY.
  - On that transition: pos=0, time_bcd=0, timeout counter=0.
- Key press qualification:
  - The keypad code must have exactly one bit set and be held unchanged for DEB_CYCLES cycles.
  - The code must have been preceded by an all-zero keypad.
  - Each press is accepted exactly once; keypad must return to all-zero before the next press qualifies.
  - Multi-bit codes reset the debounce counter and are ignored.
- ENTRY, accepted digit d at position pos, with range limits:
  - pos0 (h_ten): 0–2.
  - pos1 (h_one): 0–9, or 0–3 when h_ten==2.
  - pos2 (m_ten): 0–5.
  - pos3 (m_one): 0–9.
  - pos4 (s_ten): 0–5.
  - pos5 (s_one): 0–9.
- Valid digit: write d into its nibble, pos+1, timeout counter cleared.
- Invalid digit: err pulse; pos and time_bcd unchanged; timeout counter cleared.
- Sixth valid digit: go to COMMIT.
- COMMIT: load=1 for this one cycle, then return to IDLE. time_bcd holds its value until the next entry starts.
- Cancel: set_req low in ENTRY → IDLE, abort pulse, no load.
- Timeout: counter reaches TIMEOUT_CYCLES-1 in ENTRY → IDLE, abort pulse, no load.
- Priority when events coincide: rst > cancel > timeout > digit acceptance.
- set_req held high after COMMIT does not restart entry; a new rising edge is required.

## Timing
- Reset values: load=0, time_bcd=0, editing=0, blink_mask=0, err=0, abort=0; state IDLE; all counters 0.
- All outputs are registered.
- Key qualification: the press qualifies in the cycle the stable count reaches DEB_CYCLES. The nibble, pos, blink_mask and err update at the next edge.
- load rises on the edge that follows the edge storing the sixth digit, and stays high for exactly 1 cycle.
- editing and blink_mask change on the same edge as the state transition.
- Mid-entry reset clears everything immediately (asynchronous); no load or abort is emitted.

## Structure
- Package watch_pkg holds:
  - the FSM state enum;
  - the position indices POS_HT..POS_SO;
  - the per-position max-digit constants (2, 9/3, 5, 9, 5, 9);
  - the nibble offsets of time_bcd.
- Sub-module key_debounce (parameter DEB_CYCLES):
  - inputs: clk, rst, keypad.
  - outputs: key_valid (1-cycle pulse) and key_val[3:0].
  - Contains the one-hot check, stability counter and release latch.
- The range check and FSM stay in time_set_ctrl.

## Test plan
- Enter 1,2,3,4,5,6 after a set_req rise, each held 30 cycles with 5-cycle gaps → one load pulse, time_bcd=0x123456, blink_mask walks 100000→000001.
- Key 2 then key 5 at pos1 → err pulse, pos stays 1. Then key 3 → accepted. Complete with 5,9,5,9 → time_bcd=0x235959.
- Key 7 at pos0, and key 6 at pos2/pos4 → err each time, time_bcd unchanged.
- Key held 10 cycles (<DEB_CYCLES) → ignored. Key held 500 cycles → exactly one digit. Keys 3 and 4 pressed together → ignored.
- set_req dropped after 3 digits → abort pulse, no load. No key for 10000 cycles in ENTRY → abort pulse.
- rst asserted asynchronously mid-entry → all outputs 0 immediately; set_req held high after reset → no entry until a new rising edge.
